// File: rtl/mult_pkg.sv
// Shared types and helpers for the iterative radix-4 Booth multiplier.
package mult_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    typedef enum logic [2:0] {
        ZERO,
        POS1,
        POS2,
        NEG1,
        NEG2
    } booth_digit_t;

    // Radix-4 digits needed to recode a WIDTH-bit operand widened by two bits.
    function automatic int n_digits(input int width);
        return width / 2 + 1;
    endfunction

endpackage

// File: rtl/booth_pp_gen.sv
// Radix-4 Booth digit encoder and partial-product generator (combinational).
// pp = (digit * a_ext) << 2*idx, a true two's-complement value mod 2^(2*WIDTH).
// WIDTH must be even and at least 4.
module booth_pp_gen
    import mult_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int IDX_W = 5
) (
    input  logic [WIDTH+1:0]   i_a_ext,
    input  logic [2:0]         i_win,
    input  logic [IDX_W-1:0]   i_idx,
    output logic [2*WIDTH-1:0] o_pp
);

    localparam int PW    = 2 * WIDTH;
    localparam int EXT_W = PW - (WIDTH + 2);

    booth_digit_t              w_digit;
    logic signed [PW-1:0]      w_a_pw;
    logic signed [PW-1:0]      w_mag;
    logic signed [PW-1:0]      w_val;
    logic        [IDX_W:0]     w_shamt;

    // Window {b[2i+1], b[2i], b[2i-1]} -> digit -2*b[2i+1] + b[2i] + b[2i-1].
    always_comb begin
        w_digit = ZERO;
        case (i_win)
            3'b001, 3'b010: w_digit = POS1;
            3'b011:         w_digit = POS2;
            3'b100:         w_digit = NEG2;
            3'b101, 3'b110: w_digit = NEG1;
            default:        w_digit = ZERO;
        endcase
    end

    // a_ext is already correctly extended, so widening just replicates its top bit.
    assign w_a_pw  = {{EXT_W{i_a_ext[WIDTH+1]}}, i_a_ext};
    assign w_shamt = {i_idx, 1'b0};

    // Select |digit| * a, then apply a full negate for the negative digits.
    always_comb begin
        w_mag = '0;
        w_val = '0;
        case (w_digit)
            POS1, NEG1: w_mag = w_a_pw;
            POS2, NEG2: w_mag = w_a_pw <<< 1;
            default:    w_mag = '0;
        endcase
        if (w_digit == NEG1 || w_digit == NEG2) begin
            w_val = -w_mag;
        end else begin
            w_val = w_mag;
        end
    end

    assign o_pp = w_val << w_shamt;

endmodule

// File: rtl/booth_csa_accumulator.sv
// Iterative radix-4 Booth multiplier front end: one digit per clock folded into
// a carry-save (sum, carry) pair; the final add is left to a downstream adder.
module booth_csa_accumulator
    import mult_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic                 is_signed,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   sum_vec,
    output logic [2*WIDTH-1:0]   carry_vec
);

    localparam int N_DIGITS = n_digits(WIDTH);
    localparam int IDX_W    = $clog2(N_DIGITS);
    localparam int PW       = 2 * WIDTH;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [WIDTH+1:0]     r_a_ext;
    // b_ext with the implicit b[-1] = 0 appended at bit 0.
    logic [WIDTH+2:0]     r_b_win;
    logic [IDX_W-1:0]     r_idx;
    logic [PW-1:0]        r_sum;
    logic [PW-1:0]        r_carry;

    logic                 w_accept;
    logic                 w_last;
    logic [IDX_W:0]       w_bit_pos;
    logic [2:0]           w_win;
    logic [PW-1:0]        w_pp;
    logic [PW-1:0]        w_sum_nxt;
    logic [PW-1:0]        w_carry_nxt;

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign sum_vec   = r_sum;
    assign carry_vec = r_carry;

    assign w_accept  = in_valid && in_ready;
    assign w_last    = (r_idx == IDX_W'(N_DIGITS - 1));
    assign w_bit_pos = {r_idx, 1'b0};
    assign w_win     = r_b_win[w_bit_pos +: 3];

    booth_pp_gen #(
        .WIDTH (WIDTH),
        .IDX_W (IDX_W)
    ) u_pp_gen (
        .i_a_ext (r_a_ext),
        .i_win   (w_win),
        .i_idx   (r_idx),
        .o_pp    (w_pp)
    );

    // 3:2 compression; the carry out of the MSB is dropped (mod 2^(2*WIDTH)).
    assign w_sum_nxt   = r_sum ^ r_carry ^ w_pp;
    assign w_carry_nxt = {(r_sum[PW-2:0] & r_carry[PW-2:0]) |
                          (r_sum[PW-2:0] & w_pp[PW-2:0])    |
                          (r_carry[PW-2:0] & w_pp[PW-2:0]), 1'b0};

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic: accept in IDLE, retire all digits in RUN, hold in DONE.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: if (w_accept)  w_state_nxt = RUN;
            RUN:  if (w_last)    w_state_nxt = DONE;
            DONE: if (out_ready) w_state_nxt = IDLE;
            default:             w_state_nxt = IDLE;
        endcase
    end

    // Operand capture on accept, then one carry-save step per RUN cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a_ext <= '0;
            r_b_win <= '0;
            r_idx   <= '0;
            r_sum   <= '0;
            r_carry <= '0;
        end else if (r_state == IDLE) begin
            if (w_accept) begin
                r_a_ext <= is_signed ? {{2{a[WIDTH-1]}}, a} : {2'b00, a};
                r_b_win <= is_signed ? {{2{b[WIDTH-1]}}, b, 1'b0} : {2'b00, b, 1'b0};
                r_idx   <= '0;
                r_sum   <= '0;
                r_carry <= '0;
            end
        end else if (r_state == RUN) begin
            r_sum   <= w_sum_nxt;
            r_carry <= w_carry_nxt;
            r_idx   <= r_idx + IDX_W'(1);
        end
    end

endmodule

// File: tb/tb_booth_csa_accumulator.sv
// Directed and randomized checks of the Booth carry-save accumulator.
module tb_booth_csa_accumulator;

    localparam int W = 32;
    localparam int N = W / 2 + 1;

    logic            clk;
    logic            rst_n;
    logic            in_valid;
    logic            in_ready;
    logic [W-1:0]    a;
    logic [W-1:0]    b;
    logic            is_signed;
    logic            out_valid;
    logic            out_ready;
    logic [2*W-1:0]  sum_vec;
    logic [2*W-1:0]  carry_vec;

    int n_checks = 0;
    int n_fail   = 0;

    booth_csa_accumulator #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .is_signed (is_signed),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum_vec   (sum_vec),
        .carry_vec (carry_vec)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // a times the signed value of the low 2k bits of b_ext: the sum of the
    // first k radix-4 digits times a, mod 2^64.
    function automatic logic [63:0] partial(input logic [31:0] av, input logic [31:0] bv,
                                            input bit s, input int k);
        longint     a_v;
        longint     b_l;
        logic [33:0] bx;
        a_v = s ? longint'({{32{av[31]}}, av}) : longint'({32'b0, av});
        bx  = s ? {{2{bv[31]}}, bv} : {2'b00, bv};
        b_l = 0;
        for (int j = 0; j < 2 * k; j++) begin
            if (bx[j]) b_l += (longint'(1) << j);
        end
        if (k > 0 && bx[2*k-1]) b_l -= (longint'(1) << (2 * k));
        return 64'(a_v * b_l);
    endfunction

    function automatic logic [63:0] product(input logic [31:0] av, input logic [31:0] bv,
                                            input bit s);
        longint p;
        if (s) p = longint'($signed(av)) * longint'($signed(bv));
        else   p = longint'({32'b0, av}) * longint'({32'b0, bv});
        return 64'(p);
    endfunction

    task automatic wait_ready();
        int n;
        n = 0;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check("ready_wait", 64'(in_ready), 64'd1);
    endtask

    // Accept one operand pair and follow it to DONE, checking every RUN edge.
    // With noise set, in_valid and operands are scrambled while busy.
    task automatic run_op(input logic [31:0] av, input logic [31:0] bv, input bit s,
                          input bit noise, output logic [63:0] res);
        wait_ready();
        a = av; b = bv; is_signed = s; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk); #1;
        for (int k = 1; k <= N; k++) begin
            if (noise) begin
                in_valid = 1'b1; a = $urandom; b = $urandom; is_signed = ~s;
            end else begin
                in_valid = 1'b0;
            end
            @(posedge clk); #1;
            check("invariant", sum_vec + carry_vec, partial(av, bv, s, k));
            check("out_valid_timing", 64'(out_valid), 64'(k == N));
            check("in_ready_busy", 64'(in_ready), 64'd0);
        end
        in_valid = 1'b0;
        res = sum_vec + carry_vec;
    endtask

    task automatic release_result();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("idle_after_release", 64'(in_ready), 64'd1);
        check("valid_low_after_release", 64'(out_valid), 64'd0);
    endtask

    initial begin
        logic [63:0] res;
        logic [63:0] s0;
        logic [63:0] c0;
        logic [31:0] av;
        logic [31:0] bv;
        bit          s;
        int          hold;

        rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; is_signed = 1'b0; out_ready = 1'b0;
        #12;
        check("rst_sum", sum_vec, 64'd0);
        check("rst_carry", carry_vec, 64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Unsigned 3*5 with operands scrambled during RUN.
        run_op(32'd3, 32'd5, 1'b0, 1'b1, res);
        check("u_3x5", res, 64'd15);
        release_result();

        run_op(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b0, res);
        check("s_m1xm1", res, 64'd1);
        release_result();

        run_op(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0, res);
        check("u_maxxmax", res, 64'hFFFFFFFE00000001);
        release_result();

        run_op(32'h80000000, 32'h80000000, 1'b1, 1'b0, res);
        check("s_minxmin", res, 64'h4000000000000000);
        release_result();

        // Backpressure: hold DONE for 5 cycles.
        run_op(32'h7FFFFFFF, 32'h80000000, 1'b1, 1'b0, res);
        check("s_maxxmin", res, 64'hC000000080000000);
        s0 = sum_vec; c0 = carry_vec;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("bp_sum", sum_vec, s0);
            check("bp_carry", carry_vec, c0);
            check("bp_out_valid", 64'(out_valid), 64'd1);
            check("bp_in_ready", 64'(in_ready), 64'd0);
        end
        release_result();

        // Reset in the middle of RUN.
        a = 32'h12345; b = 32'h6789; is_signed = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (9) begin
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        #1;
        check("midrst_sum", sum_vec, 64'd0);
        check("midrst_carry", carry_vec, 64'd0);
        check("midrst_out_valid", 64'(out_valid), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("midrst_in_ready", 64'(in_ready), 64'd1);
        run_op(32'd7, 32'd9, 1'b0, 1'b0, res);
        check("u_7x9", res, 64'd63);
        release_result();

        // Randomized operands, signedness and downstream stalls.
        for (int t = 0; t < 1000; t++) begin
            av = $urandom; bv = $urandom; s = 1'($urandom_range(0, 1));
            run_op(av, bv, s, 1'b0, res);
            check("rand_product", res, product(av, bv, s));
            hold = $urandom_range(0, 3);
            s0 = sum_vec; c0 = carry_vec;
            for (int i = 0; i < hold; i++) begin
                @(posedge clk); #1;
                check("rand_hold_sum", sum_vec, s0);
                check("rand_hold_carry", carry_vec, c0);
            end
            release_result();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
